// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions (FSM state encoding, default widths, counter sizing).
package alu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int unsigned N_DEFAULT = 32;
  localparam int unsigned W_DEFAULT = 8;

  // Bits needed to count v values; never less than one so a 1-chunk counter still exists.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rca_serial_fac.sv
// fac: 1-bit full adder cell used to build the per-cycle chunk adder.
module fac (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/rca_serial.sv
// rca_serial: multi-cycle ripple-carry adder computing a + b + cin over n bits, W bits per clock.
// Start/done slave: start sampled in idle, done pulses once when res/cout/overflow update.
// Optional macro RCA_SERIAL_SUB_EN adds port 'sub' selecting a - b - cin (cout = borrow).
module rca_serial
  import alu_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
`ifdef RCA_SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [n-1:0] res,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned NCHUNK = n / W;
  localparam int unsigned CW     = clog2(NCHUNK);

  if ((n % W) != 0) begin : g_bad_w
    $error("rca_serial: n must be a multiple of W");
  end

  state_e        st_q;
  logic [CW-1:0] cnt_q;
  logic [n-1:0]  a_q;
  logic [n-1:0]  b_q;
  logic          carry_q;
`ifdef RCA_SERIAL_SUB_EN
  logic          sub_q;
`endif

  logic [W:0]    c;
  logic [W-1:0]  sum;
  logic [n-1:0]  r_next;

  // Chunk adder: W full adders rippling from the carry register.
  assign c[0] = carry_q;
  for (genvar i = 0; i < W; i++) begin : g_fac
    fac u_fac (
      .a (a_q[i]),
      .b (b_q[i]),
      .c (c[i]),
      .s (sum[i]),
      .co(c[i+1])
    );
  end

  // Result shifter holds the n-W bits of earlier chunks; the current chunk completes the word.
  if (W == n) begin : g_one_chunk
    assign r_next = sum;
  end else begin : g_multi_chunk
    logic [n-W-1:0] part_q;

    // Shift each finished chunk in from the top while busy
    always_ff @(posedge clk) begin
      if (rst) begin
        part_q <= '0;
      end else if (st_q == ST_BUSY) begin
        part_q <= r_next[n-1:W];
      end
    end

    assign r_next = {sum, part_q};
  end

  // FSM, chunk counter, operand shifters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
`ifdef RCA_SERIAL_SUB_EN
      sub_q    <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
      res      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
`ifdef RCA_SERIAL_SUB_EN
            // a - b - cin == a + ~b + ~cin
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            sub_q   <= sub;
`else
            b_q     <= b;
            carry_q <= cin;
`endif
            cnt_q   <= '0;
            busy    <= 1'b1;
            st_q    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_q     <= a_q >> W;
          b_q     <= b_q >> W;
          carry_q <= c[W];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NCHUNK - 1)) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            res      <= r_next;
            overflow <= c[W] ^ c[W-1];
`ifdef RCA_SERIAL_SUB_EN
            cout     <= c[W] ^ sub_q;
`else
            cout     <= c[W];
`endif
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial.sv
// tb_rca_serial: directed + randomized checks of rca_serial (n=32, W=8) against an
// arithmetic reference model. Define RCA_SERIAL_SUB_EN to also exercise subtraction.
module tb_rca_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
`ifdef RCA_SERIAL_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [31:0] r;
    logic        co;
    logic        ov;
  } exp_t;

  always #5 clk = ~clk;

  rca_serial #(
    .n(32),
    .W(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
`ifdef RCA_SERIAL_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .res     (res),
    .cout    (cout),
    .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, overflow from the true signed result's range.
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic c,
                                input logic s, output logic [31:0] r, output logic co,
                                output logic ov);
    logic [32:0] u;
    longint      sval;
    if (!s) begin
      u    = {1'b0, x} + {1'b0, y} + {32'd0, c};
      r    = u[31:0];
      co   = u[32];
      sval = longint'($signed(x)) + longint'($signed(y)) + longint'({31'd0, c});
    end else begin
      r    = x - y - {31'd0, c};
      co   = ({1'b0, x} < ({1'b0, y} + {32'd0, c}));
      sval = longint'($signed(x)) - longint'($signed(y)) - longint'({31'd0, c});
    end
    ov = (sval > 64'sd2147483647) || (sval < -64'sd2147483648);
  endfunction

  // Issue one op from idle and check latency, hold behaviour and result.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic tc, input logic ts);
    logic [31:0] er;
    logic [31:0] prev;
    logic        eco;
    logic        eov;
    logic        stable;
    int          lat;
    model(ta, tb2, tc, ts, er, eco, eov);
    prev = res;
    a = ta;
    b = tb2;
    cin = tc;
`ifdef RCA_SERIAL_SUB_EN
    sub = ts;
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cin = 1'b1;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " done early"}, 64'(done), 64'd0);
    lat = 0;
    stable = 1'b1;
    while (done !== 1'b1 && lat < 12) begin
      if (res !== prev) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " res held"}, 64'(stable), 64'd1);
    chk({tag, " res"}, 64'(res), 64'(er));
    chk({tag, " cout"}, 64'(cout), 64'(eco));
    chk({tag, " overflow"}, 64'(overflow), 64'(eov));
    chk({tag, " busy off"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        q[$];
    exp_t        e;
    int          next_free;
    int          ndone;
    logic [31:0] ta;
    logic [31:0] tb2;
    logic        tc;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef RCA_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset res", 64'(res), 64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("5+3", 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    chk("5+3 const", 64'(res), 64'h8);
    run_op("chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("chain const", 64'({cout, res}), 64'h1_0000_0000);
    run_op("sovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    chk("sovf const", 64'({overflow, cout, res}), 64'h2_8000_0000);
    run_op("cin", 32'h00FF_00FF, 32'h0000_FF00, 1'b1, 1'b0);
    run_op("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(1)), 1'b0);
    end

    // start held high every cycle: only starts seen while idle become ops
    next_free = 0;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        ta = $urandom;
        tb2 = $urandom;
        tc = 1'($urandom_range(1));
        a = ta;
        b = tb2;
        cin = tc;
        start = 1'b1;
        if (i >= next_free) begin
          model(ta, tb2, tc, 1'b0, e.r, e.co, e.ov);
          q.push_back(e);
          next_free = i + 5;
        end
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b res", 64'(res), 64'(e.r));
          chk("b2b cout", 64'(cout), 64'(e.co));
          chk("b2b overflow", 64'(overflow), 64'(e.ov));
        end
      end
    end
    start = 1'b0;
    chk("b2b done count", 64'(ndone), 64'd3);
    chk("b2b leftover", 64'(q.size()), 64'd0);

    // Abort mid-op: leave a known nonzero result first
    run_op("pre-abort", 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0);
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort res", 64'(res), 64'd0);
    chk("abort cout", 64'(cout), 64'd0);
    chk("abort overflow", 64'(overflow), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run_op("post-abort", 32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);

`ifdef RCA_SERIAL_SUB_EN
    run_op("3-5", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1);
    chk("3-5 const", 64'({overflow, cout, res}), 64'h1_FFFF_FFFE);
    run_op("min-1", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    chk("min-1 const", 64'({overflow, cout, res}), 64'h2_7FFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      run_op("rand sub", $urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
